// File: rtl/rtc_bus_master.sv
// rtc_bus_master: autonomous initiator that loads or coherently reads the slot RTC over its nibble bus
//   clk_i, reset_n           : 25 MHz clock, asynchronous active-low reset
//   set_req_i / read_req_i   : one-clock request pulses (set wins when both arrive together)
//   time_set_i / time_o      : 13 BCD nibbles, MSB = register 2 ... LSB = register E
//   busy_o, done_o, err_o    : sequence status, completion pulse, read retries exhausted
//   bus_cs_o, bus_addr_o, bus_rw_n_o, bus_db_o, bus_db_i, bus_ph2_o : RTC register interface
module rtc_bus_master #(
  parameter int PHASE_CLKS = 4,
  parameter int MAX_RETRY  = 3
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic        set_req_i,
  input  logic        read_req_i,
  input  logic [51:0] time_set_i,
  output logic [51:0] time_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        bus_cs_o,
  output logic [3:0]  bus_addr_o,
  output logic        bus_rw_n_o,
  output logic [7:0]  bus_db_o,
  input  logic [7:0]  bus_db_i,
  output logic        bus_ph2_o
);
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [3:0] PH_LAST = 4'(PHASE_CLKS - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  typedef enum logic [2:0] {IDLE, ACCESS_LO, ACCESS_HI, GAP, DONE} state_t;
  state_t r_state, w_next;
  logic [3:0] r_ph, r_idx, r_ref;
  logic [RW-1:0] r_retry;
  logic r_is_rd, r_err;
  logic [51:0] r_set, r_shadow, r_time;
  logic w_req, w_ph_end, w_last_acc, w_match, w_final;
  logic [3:0] w_addr, w_nib;
  logic [7:0] w_db;
  logic w_unused;
  assign w_unused = &{1'b0, bus_db_i[7:4]};
  assign w_req = set_req_i | read_req_i;
  assign w_ph_end = r_ph == PH_LAST;
  assign w_nib = bus_db_i[3:0];
  assign w_last_acc = r_idx == (r_is_rd ? 4'd14 : 4'd13);
  assign w_match = w_nib == r_ref;
  // the sweep ends once seconds are stable, writes always end, and a read gives up at the retry limit
  assign w_final = w_last_acc && (!r_is_rd || w_match || r_retry == RETRY_MAX);
  // read sweep: reference seconds-ones, registers 2..E, then a closing re-read of seconds-ones
  assign w_addr = r_is_rd ? ((r_idx == 4'd0 || r_idx == 4'd14) ? 4'hE : r_idx + 4'd1)
                          : (r_idx == 4'd13 ? 4'h0 : r_idx + 4'd2);
  assign w_db = r_is_rd ? 8'h00 : (r_idx == 4'd13 ? 8'h80 : {4'h0, r_set[51:48]});
  assign time_o = r_time;
  assign err_o = r_err;
  always_comb begin
    w_next = r_state;
    busy_o = r_state != IDLE;
    done_o = r_state == DONE;
    bus_cs_o = 1'b0;
    bus_ph2_o = 1'b0;
    bus_rw_n_o = 1'b1;
    bus_addr_o = 4'h0;
    bus_db_o = 8'h00;
    case (r_state)
      IDLE: w_next = w_req ? ACCESS_LO : IDLE;
      ACCESS_LO: begin
        w_next = w_ph_end ? ACCESS_HI : ACCESS_LO;
        bus_cs_o = 1'b1;
        bus_rw_n_o = r_is_rd;
        bus_addr_o = w_addr;
        bus_db_o = w_db;
      end
      ACCESS_HI: begin
        w_next = w_ph_end ? (w_final ? DONE : GAP) : ACCESS_HI;
        bus_cs_o = 1'b1;
        bus_ph2_o = 1'b1;
        bus_rw_n_o = r_is_rd;
        bus_addr_o = w_addr;
        bus_db_o = w_db;
      end
      GAP: begin
        w_next = ACCESS_LO;
        bus_addr_o = w_addr;
        bus_db_o = w_db;
      end
      DONE: begin
        w_next = IDLE;
        bus_addr_o = w_addr;
        bus_db_o = w_db;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_ph <= 4'd0;
      r_idx <= 4'd0;
      r_ref <= 4'd0;
      r_retry <= '0;
      r_is_rd <= 1'b0;
      r_err <= 1'b0;
      r_set <= '0;
      r_shadow <= '0;
      r_time <= '0;
    end else begin
      if (r_state == IDLE && w_req) begin
        r_is_rd <= !set_req_i;
        r_set <= time_set_i;
        r_err <= 1'b0;
        r_idx <= 4'd0;
        r_retry <= '0;
        r_ph <= 4'd0;
      end
      if (r_state == ACCESS_LO || r_state == ACCESS_HI) r_ph <= w_ph_end ? 4'd0 : r_ph + 4'd1;
      if (r_state == ACCESS_HI && w_ph_end && r_is_rd) begin
        if (r_idx == 4'd0) r_ref <= w_nib;
        else if (w_last_acc) r_shadow[3:0] <= w_nib;
        else r_shadow <= {r_shadow[47:0], w_nib};
        if (w_final) begin
          r_time <= {r_shadow[51:4], w_nib};
          r_err <= !w_match;
        end
      end
      // GAP only follows a non-final access, so reaching it on the last access means a retry
      if (r_state == GAP) begin
        r_set <= {r_set[47:0], 4'h0};
        r_idx <= w_last_acc ? 4'd0 : r_idx + 4'd1;
        if (w_last_acc && r_retry != RETRY_MAX) r_retry <= r_retry + RW'(1);
      end
    end
  end
endmodule

// File: tb/tb_rtc_bus_master.sv
// tb_rtc_bus_master: randomized directed checks of rtc_bus_master against a register-file bus model
module tb_rtc_bus_master;
  logic clk_i = 1'b0, reset_n = 1'b0, set_req_i = 1'b0, read_req_i = 1'b0;
  logic [51:0] time_set_i = '0, time_o;
  logic busy_o, done_o, err_o, bus_cs_o, bus_rw_n_o, bus_ph2_o;
  logic [3:0] bus_addr_o;
  logic [7:0] bus_db_o, bus_db_i;
  int checks = 0, fails = 0;
  logic [3:0] regs [16];
  logic [12:0] acc_q [$];
  int strobes = 0, ph2_cnt = 0, cs_cnt = 0, done_cnt = 0, mode = 0;
  logic [51:0] loaded = '0;
  logic p_ph2 = 1'b0, p_cs = 1'b0, p_rw = 1'b1;
  logic [3:0] p_addr = 4'h0;
  logic [7:0] p_db = 8'h00;

  always #20 clk_i = ~clk_i;

  rtc_bus_master dut (
    .clk_i(clk_i), .reset_n(reset_n), .set_req_i(set_req_i), .read_req_i(read_req_i),
    .time_set_i(time_set_i), .time_o(time_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .bus_cs_o(bus_cs_o), .bus_addr_o(bus_addr_o), .bus_rw_n_o(bus_rw_n_o), .bus_db_o(bus_db_o),
    .bus_db_i(bus_db_i), .bus_ph2_o(bus_ph2_o)
  );

  assign bus_db_i = (bus_cs_o && bus_rw_n_o) ? {4'h3, regs[bus_addr_o]} : 8'h00;

  function automatic logic [51:0] pack_regs();
    logic [51:0] v = '0;
    for (int a = 2; a <= 14; a++) v = {v[47:0], regs[a]};
    return v;
  endfunction

  function automatic logic [51:0] rnd_bcd();
    logic [51:0] v = '0;
    for (int i = 0; i < 13; i++) v = {v[47:0], 4'($urandom_range(0, 9))};
    return v;
  endfunction

  // bus model: logs each access, latches writes on ph2 falling, advances seconds on demand
  always @(negedge clk_i) begin
    if (bus_cs_o && !p_cs) begin
      acc_q.push_back({bus_rw_n_o, bus_addr_o, bus_db_o});
      if (bus_rw_n_o && bus_addr_o == 4'h2) begin
        if (mode == 1) begin regs[14] = 4'h0; mode = 0; end
        else if (mode == 2) regs[14] = (regs[14] == 4'h9) ? 4'h0 : regs[14] + 4'h1;
      end
    end
    if (p_ph2 && !bus_ph2_o && !p_rw) begin
      regs[p_addr] = p_db[3:0];
      if (p_addr == 4'h0 && p_db == 8'h80) begin strobes++; loaded = pack_regs(); end
    end
    ph2_cnt += int'(bus_ph2_o);
    cs_cnt += int'(bus_cs_o);
    done_cnt += int'(done_o);
    p_ph2 = bus_ph2_o; p_cs = bus_cs_o; p_rw = bus_rw_n_o; p_addr = bus_addr_o; p_db = bus_db_o;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_seq(input string tag, input bit rd, input int sweeps, input logic [51:0] t);
    int m = 0, k = 0;
    logic [12:0] e, mask;
    mask = rd ? 13'h1F00 : 13'h1FFF;
    for (int s = 0; s < (rd ? sweeps : 1); s++)
      for (int i = 0; i < (rd ? 15 : 14); i++) begin
        if (rd) e = {1'b1, (i == 0 || i == 14) ? 4'hE : 4'(i + 1), 8'h00};
        else e = (i < 13) ? {1'b0, 4'(i + 2), 4'h0, t[51-4*i -: 4]} : {1'b0, 4'h0, 8'h80};
        if (k >= acc_q.size() || ((acc_q[k] ^ e) & mask) != 13'h0) m++;
        k++;
      end
    chk({tag, "_count"}, 64'(acc_q.size()), 64'(k));
    chk({tag, "_seq_errs"}, 64'(m), 64'd0);
  endtask

  task automatic run(input bit s, input bit r, input bit mid, output int cyc, output logic b1, output logic e1);
    @(negedge clk_i);
    set_req_i = s; read_req_i = r;
    acc_q.delete();
    @(negedge clk_i);
    set_req_i = 1'b0; read_req_i = 1'b0;
    time_set_i = ~time_set_i;
    cyc = 1; b1 = busy_o; e1 = err_o;
    while (!done_o && cyc < 3000) begin
      read_req_i = mid && cyc == 20;
      @(negedge clk_i);
      cyc++;
    end
    read_req_i = 1'b0;
  endtask

  task automatic do_set(input string tag, input logic [51:0] t, input bit both, input bit mid);
    int cyc, s0, ph0, cs0;
    logic b1, e1;
    logic [51:0] t0;
    s0 = strobes; ph0 = ph2_cnt; cs0 = cs_cnt; t0 = time_o;
    time_set_i = t;
    run(1'b1, both, mid, cyc, b1, e1);
    chk({tag, "_done_clk"}, 64'(cyc), 64'd126);
    chk({tag, "_busy_rise"}, 64'(b1), 64'd1);
    chk({tag, "_err_clr"}, 64'(e1), 64'd0);
    chk({tag, "_time_o_kept"}, 64'(time_o), 64'(t0));
    chk_seq(tag, 1'b0, 1, t);
    @(negedge clk_i);
    chk({tag, "_busy_fall"}, 64'(busy_o), 64'd0);
    chk({tag, "_strobe"}, 64'(strobes - s0), 64'd1);
    chk({tag, "_loaded"}, 64'(loaded), 64'(t));
    chk({tag, "_ph2_clks"}, 64'(ph2_cnt - ph0), 64'd56);
    chk({tag, "_cs_clks"}, 64'(cs_cnt - cs0), 64'd112);
  endtask

  task automatic do_read(input string tag, input int m, input int sweeps, input bit exp_err);
    int cyc;
    logic b1, e1;
    mode = m;
    run(1'b0, 1'b1, 1'b0, cyc, b1, e1);
    chk({tag, "_done_clk"}, 64'(cyc), 64'(sweeps * 135));
    chk({tag, "_busy_rise"}, 64'(b1), 64'd1);
    chk({tag, "_time_o"}, 64'(time_o), 64'(pack_regs()));
    chk({tag, "_err"}, 64'(err_o), 64'(exp_err));
    chk_seq(tag, 1'b1, sweeps, '0);
    mode = 0;
    @(negedge clk_i);
    chk({tag, "_busy_fall"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n;
    logic [51:0] t;
    for (int a = 0; a < 16; a++) regs[a] = 4'h0;
    repeat (3) @(negedge clk_i);
    chk("reset_ctrl_bus", 64'({busy_o, done_o, err_o, bus_cs_o, bus_rw_n_o, bus_ph2_o, bus_addr_o, bus_db_o}),
        64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00}));
    chk("reset_time_o", 64'(time_o), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_i);
    do_set("set_directed", 52'h2_5_1_2_3_2_5_1_4_3_0_5_9, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) do_set("set_rand", rnd_bcd(), 1'b0, 1'b0);
    for (int a = 0; a < 16; a++) regs[a] = 4'($urandom_range(0, 9));
    do_read("read_static", 0, 1, 1'b0);
    regs[14] = 4'h9;
    do_read("read_rollover", 1, 2, 1'b0);
    chk("rollover_applied", 64'(regs[14]), 64'd0);
    do_read("read_unstable", 2, 4, 1'b1);
    d0 = done_cnt;
    do_set("set_vs_read", rnd_bcd(), 1'b1, 1'b1);
    repeat (40) @(negedge clk_i);
    chk("single_done", 64'(done_cnt - d0), 64'd1);
    chk("no_extra_access", 64'(acc_q.size()), 64'd14);
    chk("err_after_set", 64'(err_o), 64'd0);
    t = rnd_bcd();
    time_set_i = t;
    @(negedge clk_i);
    set_req_i = 1'b1;
    acc_q.delete();
    @(negedge clk_i);
    set_req_i = 1'b0;
    n = 0;
    while (acc_q.size() < 7 && n < 200) begin @(negedge clk_i); n++; end
    chk("abort_at_7th", 64'(acc_q.size()), 64'd7);
    chk("abort_7th_addr", 64'(acc_q[acc_q.size() - 1][11:8]), 64'h8);
    d0 = strobes;
    repeat (2) @(negedge clk_i);
    #5 reset_n = 1'b0;
    #1;
    chk("abort_idle", 64'({busy_o, done_o, bus_cs_o, bus_rw_n_o, bus_ph2_o, bus_addr_o, bus_db_o}),
        64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00}));
    chk("abort_time_err", 64'({err_o, time_o}), 64'd0);
    repeat (3) @(negedge clk_i);
    reset_n = 1'b1;
    repeat (20) @(negedge clk_i);
    chk("abort_no_strobe", 64'(strobes - d0), 64'd0);
    chk("abort_no_more_access", 64'(acc_q.size()), 64'd7);
    chk("abort_busy", 64'(busy_o), 64'd0);
    do_set("set_after_abort", rnd_bcd(), 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/rtc_bus_master.md
Name: rtc_bus_master

Overview:
- Autonomous bus initiator for the slot real-time clock's 16-register nibble interface.
- Issues the write sequence that loads a full BCD date/time and fires the set strobe.
- Issues a coherent read sweep of all time fields, retrying if the seconds roll over mid-sweep.
- Sits between a time source or consumer (UART time loader, display/status logic) and the clock's cs/address/rw/db/ph_2 interface, driving that interface in place of the CPU.

Parameters:
- PHASE_CLKS, 4, clk_i cycles per bus_ph2_o half-phase (legal range 2..15).
- MAX_RETRY, 3, extra read sweeps allowed after a seconds-mismatch before flagging an error.

Ports:
- clk_i  in  1  system clock (25 MHz)
- reset_n  in  1  asynchronous active-low reset
- set_req_i  in  1  one-clock pulse: start the write/set sequence
- read_req_i  in  1  one-clock pulse: start the read sweep
- time_set_i  in  52  13 BCD nibbles, MSB nibble = register 2 (years tens) ... LSB nibble = register E (seconds ones)
- time_o  out  52  captured time, same packing as time_set_i
- busy_o  out  1  sequence in progress
- done_o  out  1  one-clock completion pulse
- err_o  out  1  last read exhausted its retries; held until the next request is accepted
- bus_cs_o  out  1  clock module chip select
- bus_addr_o  out  4  register address
- bus_rw_n_o  out  1  1 = read, 0 = write
- bus_db_o  out  8  write data
- bus_db_i  in  8  read data (upper nibble is 0x3, lower nibble is the field)
- bus_ph2_o  out  1  bus phase clock; the target latches writes on its falling edge

Behaviour:
- Reset (asynchronous, immediate, including mid-sequence):
  - Bus outputs idle: bus_cs_o=0, bus_addr_o=0, bus_rw_n_o=1, bus_db_o=0, bus_ph2_o=0.
  - busy_o=0, done_o=0, err_o=0, time_o=0.
  - Any in-flight sequence is abandoned; no set strobe is issued.
- States: IDLE, ACCESS_LO, ACCESS_HI, GAP, DONE.
- Access timing:
  - ACCESS_LO: PHASE_CLKS clocks, bus_ph2_o=0. bus_cs_o=1; bus_addr_o, bus_rw_n_o and bus_db_o stable.
  - ACCESS_HI: PHASE_CLKS clocks, bus_ph2_o=1, all other bus outputs held. Read data sampled from bus_db_i[3:0] on the last clock of ACCESS_HI.
  - GAP: one clock with bus_cs_o=0, bus_ph2_o=0, bus_rw_n_o=1.
  - One access = 2*PHASE_CLKS+1 clocks.
- Request acceptance:
  - Requests are sampled only in IDLE.
  - If set_req_i and read_req_i arrive in the same clock, set wins and the read is dropped.
  - Requests arriving while busy_o=1 are ignored.
  - busy_o rises the clock after acceptance.
  - time_set_i is registered at acceptance; later changes have no effect.
- Set sequence (14 accesses):
  - Writes to addresses 2,3,...,E, each with bus_db_o={4'h0, nibble}.
  - Then address 0 with bus_db_o=8'h80 (set strobe).
  - time_o is unchanged; err_o is cleared.
- Read sweep (15 accesses):
  - Address E (seconds ones, reference copy), then addresses 2..E, capturing each nibble into a shadow register.
  - If the final seconds-ones nibble equals the reference nibble: copy the shadow to time_o, err_o=0, finish.
  - Otherwise retry the full sweep, up to MAX_RETRY retries (MAX_RETRY+1 sweeps in total).
  - If all sweeps mismatch: time_o takes the last sweep's shadow, err_o=1.
- Completion:
  - done_o=1 for exactly one clock, coinciding with the GAP clock of the final access.
  - busy_o=0 from the next clock; return to IDLE.
  - A new request is accepted in the clock after done_o.
- Counters:
  - Phase counter 4 bits; access index 4 bits; retry counter ceil(log2(MAX_RETRY+1)) bits.
  - No wrap: the retry counter saturates at MAX_RETRY.

Test Plan:
- Reset, then set_req_i with time_set_i=52'h2_5_1_2_3_2_5_1_4_3_0_5_9, PHASE_CLKS=4 -> 14 accesses at addresses 2..E then 0, data 0x02,0x05,...,0x09 then 0x80; done_o at clock 126 after acceptance; bus model confirms the load.
- Read with a static bus model returning 0x30|nibble -> 15 accesses, first address E; done_o at clock 135; time_o equals the model contents; err_o=0.
- Read where seconds ones changes 9->0 mid-sweep once -> exactly one retry, 30 accesses total; time_o matches the post-rollover value; err_o=0.
- Read with seconds ones changing on every sweep, MAX_RETRY=3 -> 4 sweeps (60 accesses); err_o=1; next accepted set_req_i clears err_o.
- set_req_i and read_req_i in the same clock -> write sequence only; read_req_i pulsed while busy is ignored, so a single done_o pulse occurs.
- reset_n asserted during the 7th write access -> bus idle values immediately, address 0 never written, busy_o=0; a new set request afterwards completes normally.
